// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and the oversampling ratio
// common to the transmitter and receiver.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// UART serializer: start bit, DBIT data bits LSB first, optional parity, stop bit(s),
// each bit timed by counting 16x oversampling ticks from the baud divisor.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PAR_EN  = 0,
  parameter int PAR_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [4:0]    S_BIT_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0]    S_STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  tx_state_t       state_reg, state_next;
  logic [4:0]      s_reg, s_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            p_reg, p_next;
  logic            tx_reg, tx_next;
  logic            busy_reg;
  logic            done_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      p_reg     <= 1'b0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      p_reg     <= p_next;
      tx_reg    <= tx_next;
      busy_reg  <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    p_next     = p_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        // A tick coinciding with acceptance is deliberately not counted.
        if (tx_start) begin
          b_next     = din;
          p_next     = (^din) ^ (PAR_ODD != 0);
          s_next     = '0;
          n_next     = '0;
          state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == S_BIT_LAST) begin
            s_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == S_BIT_LAST) begin
            s_next = '0;
            b_next = b_reg >> 1;
            if (n_reg == N_LAST) begin
              state_next = (PAR_EN != 0) ? PARITY : STOP;
            end else begin
              n_next = n_reg + 1'b1;
            end
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_reg == S_BIT_LAST) begin
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_reg == S_STOP_LAST) begin
            s_next     = '0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is decoded from the upcoming state and registered, so tx never glitches.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
      PARITY:  tx_next = p_next;
      default: tx_next = 1'b1;
    endcase
  end

  assign tx           = tx_reg;
  assign tx_busy      = busy_reg;
  assign tx_done_tick = done_next & ~reset;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameterisations share one stimulus stream and are checked
// every cycle against a tick-counting frame model, plus literal spot checks.
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic       tx_start;
  logic [7:0] din;
  logic       tx_w   [4];
  logic       busy_w [4];
  logic       done_w [4];

  // dut0: 8N1, dut1: 8E1, dut2: 8N2 (SB_TICK=32), dut3: 8O1
  uart_tx #(.DBIT(8), .SB_TICK(16), .PAR_EN(0), .PAR_ODD(0)) dut0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]), .tx(tx_w[0]));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PAR_EN(1), .PAR_ODD(0)) dut1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx_busy(busy_w[1]), .tx_done_tick(done_w[1]), .tx(tx_w[1]));
  uart_tx #(.DBIT(8), .SB_TICK(32), .PAR_EN(0), .PAR_ODD(0)) dut2 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx_busy(busy_w[2]), .tx_done_tick(done_w[2]), .tx(tx_w[2]));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PAR_EN(1), .PAR_ODD(1)) dut3 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx_busy(busy_w[3]), .tx_done_tick(done_w[3]), .tx(tx_w[3]));

  int cfg_pe [4] = '{0, 1, 0, 1};
  int cfg_po [4] = '{0, 0, 0, 1};
  int cfg_sb [4] = '{16, 16, 32, 16};

  int n_cmp    = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit chk_en   = 0;
  bit tick_en  = 0;
  int tcnt     = 0;
  int done_cnt [4] = '{0, 0, 0, 0};
  int done_cyc [4] = '{0, 0, 0, 0};

  // Frame model: line level as a function of ticks consumed since acceptance
  bit m_busy [4] = '{0, 0, 0, 0};
  int m_k    [4] = '{0, 0, 0, 0};
  int m_nb   [4] = '{9, 9, 9, 9};
  bit m_bits [4][10];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt   = (tcnt + 1) % 4;
      s_tick = tick_en && (tcnt == 0);
    end
  end

  task automatic chk_bit(input string name, input int idx, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s dut%0d cycle %0d: got %0b, expected %0b", name, idx, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the model, then advance the model across the coming edge.
  always @(negedge clk) begin
    logic exp_tx;
    logic exp_done;
    int   tot;
    for (int i = 0; i < 4; i++) begin
      tot = 16 * m_nb[i] + cfg_sb[i];
      if (!m_busy[i])                exp_tx = 1'b1;
      else if (m_k[i] < 16*m_nb[i])  exp_tx = m_bits[i][m_k[i] / 16];
      else                           exp_tx = 1'b1;
      exp_done = !reset && m_busy[i] && s_tick && (m_k[i] == tot - 1);
      if (chk_en) begin
        chk_bit("tx", i, tx_w[i], exp_tx);
        chk_bit("tx_busy", i, busy_w[i], m_busy[i]);
        chk_bit("tx_done_tick", i, done_w[i], exp_done);
      end
      if (done_w[i] === 1'b1) begin
        done_cnt[i]++;
        done_cyc[i] = cyc;
        $display("dut%0d frame done at cycle %0d", i, cyc);
      end
      if (reset) begin
        m_busy[i] = 1'b0;
        m_k[i]    = 0;
      end else if (!m_busy[i] && tx_start) begin
        m_busy[i]    = 1'b1;
        m_k[i]       = 0;
        m_bits[i][0] = 1'b0;
        for (int j = 0; j < 8; j++) m_bits[i][1+j] = din[j];
        m_bits[i][9] = (^din) ^ (cfg_po[i] != 0);
        m_nb[i]      = 9 + cfg_pe[i];
      end else if (m_busy[i] && s_tick) begin
        if (m_k[i] == tot - 1) m_busy[i] = 1'b0;
        else                   m_k[i]++;
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic start_frame(input logic [7:0] d, output int acc);
    int guard;
    guard = 0;
    do begin
      @(posedge clk);
      #2;
      guard++;
    end while (!s_tick && guard < 20);
    if (!s_tick) chk_int("tick_sync_timeout", 0, 1);
    din      = d;
    tx_start = 1'b1;
    acc      = cyc;
    @(posedge clk);
    #2;
    tx_start = 1'b0;
  endtask

  task automatic wait_done(input int idx, input int base, input int limit, output int dcyc);
    int n;
    n = 0;
    while (done_cnt[idx] == base && n < limit) begin
      @(posedge clk);
      #3;
      n++;
    end
    if (done_cnt[idx] == base) begin
      chk_int("done_timeout", 0, 1);
      dcyc = -1;
    end else begin
      dcyc = done_cyc[idx];
    end
  endtask

  initial begin
    int acc;
    int d;
    int base;
    logic [9:0] a5_line;
    a5_line  = 10'b1101001010;
    reset    = 1'b1;
    tx_start = 1'b0;
    din      = 8'h00;
    tick_en  = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b1;
    #1;
    chk_bit("reset_tx", 0, tx_w[0], 1'b1);
    chk_bit("reset_busy", 0, busy_w[0], 1'b0);
    chk_bit("reset_done", 0, done_w[0], 1'b0);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // 8'hA5: bit levels mid-bit, done latency 640 clk
    base = done_cnt[0];
    start_frame(8'hA5, acc);
    for (int i = 0; i < 10; i++) begin
      wait_until(acc + 64*i + 32);
      chk_bit("a5_bit", 0, tx_w[0], a5_line[i]);
      chk_bit("a5_busy", 0, busy_w[0], 1'b1);
    end
    wait_done(0, base, 1000, d);
    chk_int("a5_done_latency", d - acc, 640);
    wait_until(acc + 760);
    chk_int("a5_done_count", done_cnt[0] - base, 1);
    for (int i = 0; i < 4; i++) chk_bit("a5_idle_busy", i, busy_w[i], 1'b0);

    // 8'h07: even parity 1, odd parity 0, 11-bit frame
    base = done_cnt[1];
    start_frame(8'h07, acc);
    wait_until(acc + 608);
    chk_bit("parity_even", 1, tx_w[1], 1'b1);
    chk_bit("parity_odd", 3, tx_w[3], 1'b0);
    wait_done(1, base, 1000, d);
    chk_int("parity_done_latency", d - acc, 704);
    wait_until(acc + 760);

    // 8'h00 with two stop bits: done at tick 176
    base = done_cnt[2];
    start_frame(8'h00, acc);
    wait_until(acc + 650);
    chk_bit("sb32_stop_tx", 2, tx_w[2], 1'b1);
    chk_bit("sb32_stop_busy", 2, busy_w[2], 1'b1);
    chk_bit("sb16_idle_busy", 0, busy_w[0], 1'b0);
    wait_done(2, base, 1000, d);
    chk_int("sb32_done_latency", d - acc, 704);
    wait_until(acc + 760);

    // tx_start held: one frame, then re-accept in the single idle cycle
    base = done_cnt[0];
    start_frame(8'h3C, acc);
    tx_start = 1'b1;
    wait_done(0, base, 1000, d);
    chk_int("held_done_latency", d - acc, 640);
    wait_until(d + 1);
    chk_bit("held_gap_tx", 0, tx_w[0], 1'b1);
    chk_bit("held_gap_busy", 0, busy_w[0], 1'b0);
    wait_until(d + 2);
    chk_bit("held_restart_tx", 0, tx_w[0], 1'b0);
    chk_bit("held_restart_busy", 0, busy_w[0], 1'b1);
    chk_int("held_single_frame", done_cnt[0] - base, 1);
    tx_start = 1'b0;
    wait_until(d + 900);
    for (int i = 0; i < 4; i++) chk_bit("held_drain_busy", i, busy_w[i], 1'b0);

    // reset during data bit 3 aborts cleanly, then 8'h81 sends normally
    start_frame(8'h5A, acc);
    wait_until(acc + 288);
    reset = 1'b1;
    base  = done_cnt[0];
    @(posedge clk);
    #3;
    for (int i = 0; i < 4; i++) begin
      chk_bit("abort_tx", i, tx_w[i], 1'b1);
      chk_bit("abort_busy", i, busy_w[i], 1'b0);
    end
    reset = 1'b0;
    wait_until(cyc + 700);
    chk_int("abort_no_done", done_cnt[0] - base, 0);
    start_frame(8'h81, acc);
    wait_done(0, base, 1000, d);
    chk_int("after_abort_latency", d - acc, 640);
    wait_until(acc + 760);

    // no ticks: line stays at the start level
    tick_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    base     = done_cnt[0];
    din      = 8'h55;
    tx_start = 1'b1;
    @(posedge clk);
    #2;
    tx_start = 1'b0;
    repeat (400) @(posedge clk);
    #3;
    chk_bit("stall_tx", 0, tx_w[0], 1'b0);
    chk_bit("stall_busy", 0, busy_w[0], 1'b1);
    chk_int("stall_no_done", done_cnt[0] - base, 0);

    reset = 1'b1;
    @(posedge clk);
    #3;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
